// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the 8-bit ALUSystem datapath. It fetches a 16-bit
// instruction as two bytes into IR (low byte first), decodes it, and drives
// every ALUSystem control input cycle by cycle. It observes only IROut and
// ALUOutFlag.
//
// Ports
//   Clock        in   1   rising-edge clock
//   Reset        in   1   synchronous, active-low; forces INIT
//   IROut        in  16   IR contents: [15:12] opcode, [11:10] Rd, [9:8] Rs,
//                         [7:0] immediate/address
//   ALUOutFlag   in   4   {Z,C,N,O}
//   RF_OutASel   out  2   RF A-port select, 00..11 = R1..R4
//   RF_OutBSel   out  2   RF B-port select, 00..11 = R1..R4
//   RF_FunSel    out  2   00 clear, 01 load, 10 decrement, 11 increment
//   RF_RegSel    out  4   active-low enables, bit3=R1 .. bit0=R4
//   ALU_FunSel   out  4   0000 pass A, 0100 A+B, 0101 A-B
//   ARF_OutCSel  out  2   00 PC, 01 AR, 10 SP, 11 AR
//   ARF_OutDSel  out  2   00 PC, 01 AR, 10 SP, 11 AR (memory address)
//   ARF_FunSel   out  2   same coding as RF_FunSel
//   ARF_RegSel   out  3   active-low enables, bit2=PC, bit1=AR, bit0=SP
//   IR_LH        out  1   0 loads IR[7:0], 1 loads IR[15:8]
//   IR_Enable    out  1   IR write enable
//   IR_Funsel    out  2   01 = load
//   Mem_WR       out  1   1 = write
//   Mem_CS       out  1   active-low chip select
//   MuxASel      out  2   RF input: 00 ALUOut, 01 MemOut, 10 IR[7:0], 11 ARF COut
//   MuxBSel      out  2   ARF input: same coding as MuxASel
//   MuxCSel      out  1   ALU A input: 0 RF AOut, 1 ARF COut
//   Halted       out  1   high while in HALT
//   State        out  3   current state (debug): INIT=0, T0=1, T1=2, T2=3,
//                         T3=4, HALT=5
//------------------------------------------------------------------------------
module control_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  ALUOutFlag,
   output logic [1:0]  RF_OutASel,
   output logic [1:0]  RF_OutBSel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic [1:0]  IR_Funsel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted,
   output logic [2:0]  State
);

   // State codes
   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_T0   = 3'd1;
   localparam logic [2:0] S_T1   = 3'd2;
   localparam logic [2:0] S_T2   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   // Opcodes
   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ST  = 4'h2;
   localparam logic [3:0] OP_MOV = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_INC = 4'h6;
   localparam logic [3:0] OP_BRA = 4'h7;
   localparam logic [3:0] OP_BNE = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Register-file / ARF function codes
   localparam logic [1:0] FUN_CLEAR = 2'b00;
   localparam logic [1:0] FUN_LOAD  = 2'b01;
   localparam logic [1:0] FUN_INC   = 2'b11;

   // ALU function codes
   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0101;

   // MuxA/MuxB source codes
   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_MEM = 2'b01;
   localparam logic [1:0] MUX_IMM = 2'b10;

   // ARF output selects and active-low write enables
   localparam logic [1:0] ARF_SEL_PC = 2'b00;
   localparam logic [1:0] ARF_SEL_AR = 2'b01;
   localparam logic [2:0] ARF_EN_PC  = 3'b011;
   localparam logic [2:0] ARF_EN_AR  = 3'b101;

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic [3:0] w_opcode;
   logic [1:0] w_rd;
   logic [1:0] w_rs;
   logic [3:0] w_rd_regsel;
   logic       w_zero;
   logic       w_unused;

   assign w_opcode = IROut[15:12];
   assign w_rd     = IROut[11:10];
   assign w_rs     = IROut[9:8];
   assign w_zero   = ALUOutFlag[3];

   // Active-low one-cold enable for Rd: R1 sits at bit3, R4 at bit0.
   assign w_rd_regsel = ~(4'b1000 >> w_rd);

   // The immediate is routed by the datapath muxes, and only Z is consumed.
   assign w_unused = &{1'b0, IROut[7:0], ALUOutFlag[2:0]};

   assign State = r_state;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_next_state = S_INIT;
      case (r_state)
         S_INIT: w_next_state = S_T0;
         S_T0:   w_next_state = S_T1;
         S_T1:   w_next_state = S_T2;
         S_T2: begin
            case (w_opcode)
               OP_LD, OP_ST: w_next_state = S_T3;
               OP_HLT:       w_next_state = S_HALT;
               default:      w_next_state = S_T0;
            endcase
         end
         S_T3:   w_next_state = S_T0;
         S_HALT: w_next_state = S_HALT;
         default: w_next_state = S_INIT;  // unused codes recover through INIT
      endcase
   end

   //---------------------------------------------------------------------------
   // Control outputs: idle unless the current state/opcode asks for something.
   // Reset low overrides everything so no write can occur in a reset cycle.
   //---------------------------------------------------------------------------
   always_comb begin
      RF_OutASel  = '0;
      RF_OutBSel  = '0;
      RF_FunSel   = '0;
      RF_RegSel   = '1;
      ALU_FunSel  = '0;
      ARF_OutCSel = '0;
      ARF_OutDSel = '0;
      ARF_FunSel  = '0;
      ARF_RegSel  = '1;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      IR_Funsel   = '0;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = '0;
      MuxBSel     = '0;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;

      if (Reset) begin
         case (r_state)
            S_INIT: begin
               RF_FunSel  = FUN_CLEAR;
               RF_RegSel  = '0;
               ARF_FunSel = FUN_CLEAR;
               ARF_RegSel = '0;
            end

            // Byte fetch from M[PC] into IR, PC incremented in the same cycle.
            S_T0, S_T1: begin
               ARF_OutDSel = ARF_SEL_PC;
               Mem_CS      = 1'b0;
               Mem_WR      = 1'b0;
               IR_Enable   = 1'b1;
               IR_Funsel   = FUN_LOAD;
               IR_LH       = (r_state == S_T1);
               ARF_RegSel  = ARF_EN_PC;
               ARF_FunSel  = FUN_INC;
            end

            S_T2: begin
               case (w_opcode)
                  OP_LDI: begin
                     MuxASel   = MUX_IMM;
                     RF_FunSel = FUN_LOAD;
                     RF_RegSel = w_rd_regsel;
                  end
                  OP_LD, OP_ST: begin
                     MuxBSel    = MUX_IMM;
                     ARF_RegSel = ARF_EN_AR;
                     ARF_FunSel = FUN_LOAD;
                  end
                  OP_MOV: begin
                     RF_OutASel = w_rs;
                     ALU_FunSel = ALU_PASS_A;
                     MuxASel    = MUX_ALU;
                     RF_FunSel  = FUN_LOAD;
                     RF_RegSel  = w_rd_regsel;
                  end
                  OP_ADD, OP_SUB: begin
                     RF_OutASel = w_rd;
                     RF_OutBSel = w_rs;
                     ALU_FunSel = (w_opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                     MuxASel    = MUX_ALU;
                     RF_FunSel  = FUN_LOAD;
                     RF_RegSel  = w_rd_regsel;
                  end
                  OP_INC: begin
                     RF_FunSel = FUN_INC;
                     RF_RegSel = w_rd_regsel;
                  end
                  OP_BRA: begin
                     MuxBSel    = MUX_IMM;
                     ARF_RegSel = ARF_EN_PC;
                     ARF_FunSel = FUN_LOAD;
                  end
                  OP_BNE: begin
                     // Branch taken only when the Z flag is clear.
                     if (!w_zero) begin
                        MuxBSel    = MUX_IMM;
                        ARF_RegSel = ARF_EN_PC;
                        ARF_FunSel = FUN_LOAD;
                     end
                  end
                  default: ;  // HLT and 9..E are idle here
               endcase
            end

            S_T3: begin
               case (w_opcode)
                  OP_LD: begin
                     ARF_OutDSel = ARF_SEL_AR;
                     Mem_CS      = 1'b0;
                     MuxASel     = MUX_MEM;
                     RF_FunSel   = FUN_LOAD;
                     RF_RegSel   = w_rd_regsel;
                  end
                  OP_ST: begin
                     ARF_OutDSel = ARF_SEL_AR;
                     RF_OutASel  = w_rd;
                     MuxCSel     = 1'b0;
                     ALU_FunSel  = ALU_PASS_A;
                     Mem_CS      = 1'b0;
                     Mem_WR      = 1'b1;
                  end
                  default: ;
               endcase
            end

            S_HALT: Halted = 1'b1;

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer
//
// Drives control_sequencer from a small emulation of the ALUSystem datapath
// (RF, ARF, IR, ALU, memory, muxes) that obeys the control outputs, and checks
// architectural results against an instruction-level reference model.
//------------------------------------------------------------------------------
module tb_control_sequencer;

   logic        Clock;
   logic        Reset;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]  RF_RegSel, ALU_FunSel;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH, IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel, Halted;
   logic [2:0]  State;

   control_sequencer dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
      .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
      .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
      .Halted(Halted), .State(State)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_T0   = 3'd1;
   localparam logic [2:0] ST_T1   = 3'd2;
   localparam logic [2:0] ST_T2   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_HALT = 3'd5;

   // Full control vector, field order:
   // OutA OutB RFfun RFreg ALU OutC OutD ARFfun ARFreg LH IRen IRfun WR CS MuxA MuxB MuxC
   logic [33:0] ctl;
   assign ctl = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
                 ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH,
                 IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

   localparam logic [33:0] V_IDLE  = {2'b00,2'b00,2'b00,4'hF,4'h0,2'b00,2'b00,2'b00,3'b111,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,2'b00,1'b0};
   localparam logic [33:0] V_INIT  = {2'b00,2'b00,2'b00,4'h0,4'h0,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,2'b00,1'b0};
   localparam logic [33:0] V_FET0  = {2'b00,2'b00,2'b00,4'hF,4'h0,2'b00,2'b00,2'b11,3'b011,1'b0,1'b1,2'b01,1'b0,1'b0,2'b00,2'b00,1'b0};
   localparam logic [33:0] V_FET1  = {2'b00,2'b00,2'b00,4'hF,4'h0,2'b00,2'b00,2'b11,3'b011,1'b1,1'b1,2'b01,1'b0,1'b0,2'b00,2'b00,1'b0};
   localparam logic [33:0] V_LDI_R2 = {2'b00,2'b00,2'b01,4'b1011,4'h0,2'b00,2'b00,2'b00,3'b111,1'b0,1'b0,2'b00,1'b0,1'b1,2'b10,2'b00,1'b0};
   localparam logic [33:0] V_LDAR  = {2'b00,2'b00,2'b00,4'hF,4'h0,2'b00,2'b00,2'b01,3'b101,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,2'b10,1'b0};
   localparam logic [33:0] V_ST_R2 = {2'b01,2'b00,2'b00,4'hF,4'h0,2'b00,2'b01,2'b00,3'b111,1'b0,1'b0,2'b00,1'b1,1'b0,2'b00,2'b00,1'b0};
   localparam logic [33:0] V_BRPC  = {2'b00,2'b00,2'b00,4'hF,4'h0,2'b00,2'b00,2'b01,3'b011,1'b0,1'b0,2'b00,1'b0,1'b1,2'b00,2'b10,1'b0};

   int checks = 0;
   int errors = 0;

   // Emulated datapath
   logic [7:0]  R [4];
   logic [7:0]  pc, ar, sp;
   logic [15:0] ir;
   logic [7:0]  mem [256];
   assign IROut = ir;

   // Instruction-level reference model
   logic [7:0]  m_r [4];
   logic [7:0]  m_pc;
   logic [7:0]  m_mem [256];
   logic        m_halted;

   function automatic logic [7:0] apply_fun(input logic [1:0] f, input logic [7:0] cur,
                                            input logic [7:0] d);
      case (f)
         2'b00:   return 8'h00;
         2'b01:   return d;
         2'b10:   return cur - 8'd1;
         default: return cur + 8'd1;
      endcase
   endfunction

   function automatic logic [7:0] arf_out(input logic [1:0] s);
      case (s)
         2'b00:   return pc;
         2'b10:   return sp;
         default: return ar;
      endcase
   endfunction

   function automatic logic [7:0] mux4(input logic [1:0] s, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d);
      case (s)
         2'b00:   return a;
         2'b01:   return b;
         2'b10:   return c;
         default: return d;
      endcase
   endfunction

   // One clock of the datapath: sample controls at negedge, commit after posedge.
   task automatic tick();
      logic [7:0]  a_rf, b_rf, c_arf, d_arf, alu_a, alu_o, mem_o, mux_a, mux_b;
      logic [7:0]  nR [4];
      logic [7:0]  n_pc, n_ar, n_sp;
      logic [15:0] n_ir;
      logic        do_wr;
      @(negedge Clock);
      a_rf  = R[RF_OutASel];
      b_rf  = R[RF_OutBSel];
      c_arf = arf_out(ARF_OutCSel);
      d_arf = arf_out(ARF_OutDSel);
      alu_a = MuxCSel ? c_arf : a_rf;
      case (ALU_FunSel)
         4'b0000: alu_o = alu_a;
         4'b0100: alu_o = alu_a + b_rf;
         4'b0101: alu_o = alu_a - b_rf;
         default: alu_o = 8'h00;
      endcase
      mem_o = Mem_CS ? 8'h00 : mem[d_arf];
      mux_a = mux4(MuxASel, alu_o, mem_o, ir[7:0], c_arf);
      mux_b = mux4(MuxBSel, alu_o, mem_o, ir[7:0], c_arf);
      for (int i = 0; i < 4; i++)
         nR[i] = RF_RegSel[3-i] ? R[i] : apply_fun(RF_FunSel, R[i], mux_a);
      n_pc = ARF_RegSel[2] ? pc : apply_fun(ARF_FunSel, pc, mux_b);
      n_ar = ARF_RegSel[1] ? ar : apply_fun(ARF_FunSel, ar, mux_b);
      n_sp = ARF_RegSel[0] ? sp : apply_fun(ARF_FunSel, sp, mux_b);
      n_ir = ir;
      if (IR_Enable && IR_Funsel == 2'b01) begin
         if (IR_LH) n_ir[15:8] = mem_o;
         else       n_ir[7:0]  = mem_o;
      end
      do_wr = !Mem_CS && Mem_WR;
      @(posedge Clock);
      #1;
      for (int i = 0; i < 4; i++) R[i] = nR[i];
      pc = n_pc; ar = n_ar; sp = n_sp; ir = n_ir;
      if (do_wr) mem[d_arf] = alu_o;
      #1;
   endtask

   // Leaves the DUT in INIT with Reset released.
   task automatic do_reset();
      Reset = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      #1;
   endtask

   task automatic isa_step(input logic z, output int cyc);
      logic [15:0] w;
      logic [1:0]  rd, rs;
      logic [7:0]  imm;
      w    = {m_mem[m_pc + 8'd1], m_mem[m_pc]};
      m_pc = m_pc + 8'd2;
      rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
      cyc = 3;
      case (w[15:12])
         4'h0: m_r[rd] = imm;
         4'h1: begin m_r[rd] = m_mem[imm]; cyc = 4; end
         4'h2: begin m_mem[imm] = m_r[rd]; cyc = 4; end
         4'h3: m_r[rd] = m_r[rs];
         4'h4: m_r[rd] = m_r[rd] + m_r[rs];
         4'h5: m_r[rd] = m_r[rd] - m_r[rs];
         4'h6: m_r[rd] = m_r[rd] + 8'd1;
         4'h7: m_pc = imm;
         4'h8: if (!z) m_pc = imm;
         4'hF: m_halted = 1'b1;
         default: ;
      endcase
   endtask

   task automatic load_directed();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h2A; mem[1] = 8'h04;          // LDI R2,0x2A
      mem[2] = 8'h55; mem[3] = 8'h24;          // ST  R2,0x55
      mem[4] = 8'h10; mem[5] = 8'h80;          // BNE 0x10 (Z=1)
      mem[6] = 8'h10; mem[7] = 8'h80;          // BNE 0x10 (Z=0)
      mem[8'h10] = 8'h00; mem[8'h11] = 8'hF0;  // HLT
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      tick();
      tick();
      checks++;
      if (State !== ST_INIT || Halted !== 1'b0) begin
         errors++; $display("FAIL reset_low_state: got %0d/%b expected %0d/0", State, Halted, ST_INIT);
      end
      checks++;
      if (ctl !== V_IDLE) begin
         errors++; $display("FAIL reset_low_idle: got %h expected %h", ctl, V_IDLE);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if (ctl !== V_INIT || State !== ST_INIT) begin
         errors++; $display("FAIL init_outputs: got %h/%0d expected %h/%0d", ctl, State, V_INIT, ST_INIT);
      end
      tick();
      checks++;
      if (ctl !== V_FET0 || State !== ST_T0) begin
         errors++; $display("FAIL t0_outputs: got %h/%0d expected %h/%0d", ctl, State, V_FET0, ST_T0);
      end
   endtask

   task automatic test_ldi();
      tick();
      checks++;
      if (ctl !== V_FET1 || State !== ST_T1) begin
         errors++; $display("FAIL t1_outputs: got %h/%0d expected %h/%0d", ctl, State, V_FET1, ST_T1);
      end
      tick();
      checks++;
      if (IROut !== 16'h042A) begin
         errors++; $display("FAIL ldi_ir: got %h expected 042a", IROut);
      end
      checks++;
      if (ctl !== V_LDI_R2) begin
         errors++; $display("FAIL ldi_t2: got %h expected %h", ctl, V_LDI_R2);
      end
      tick();
      checks++;
      if (R[1] !== 8'h2A || pc !== 8'h02 || State !== ST_T0) begin
         errors++; $display("FAIL ldi_result: got R2=%h PC=%h st=%0d expected 2a 02 %0d", R[1], pc, State, ST_T0);
      end
   endtask

   task automatic test_st();
      tick();
      tick();
      checks++;
      if (IROut !== 16'h2455 || ctl !== V_LDAR) begin
         errors++; $display("FAIL st_t2: got %h/%h expected 2455/%h", IROut, ctl, V_LDAR);
      end
      tick();
      checks++;
      if (ctl !== V_ST_R2 || State !== ST_T3) begin
         errors++; $display("FAIL st_t3: got %h/%0d expected %h/%0d", ctl, State, V_ST_R2, ST_T3);
      end
      tick();
      checks++;
      if (mem[8'h55] !== 8'h2A || State !== ST_T0) begin
         errors++; $display("FAIL st_result: got M=%h st=%0d expected 2a %0d", mem[8'h55], State, ST_T0);
      end
   endtask

   task automatic test_bne();
      ALUOutFlag = 4'b1000;
      tick();
      tick();
      checks++;
      if (IROut !== 16'h8010 || ctl !== V_IDLE) begin
         errors++; $display("FAIL bne_z1_t2: got %h/%h expected 8010/%h", IROut, ctl, V_IDLE);
      end
      tick();
      checks++;
      if (pc !== 8'h06 || State !== ST_T0) begin
         errors++; $display("FAIL bne_z1_pc: got %h/%0d expected 06/%0d", pc, State, ST_T0);
      end
      ALUOutFlag = 4'b0111;
      tick();
      tick();
      checks++;
      if (ctl !== V_BRPC) begin
         errors++; $display("FAIL bne_z0_t2: got %h expected %h", ctl, V_BRPC);
      end
      tick();
      checks++;
      if (pc !== 8'h10) begin
         errors++; $display("FAIL bne_z0_pc: got %h expected 10", pc);
      end
   endtask

   task automatic test_halt();
      tick();
      tick();
      tick();
      for (int unsigned n = 0; n < 20; n++) begin
         checks++;
         if (State !== ST_HALT || Halted !== 1'b1 || ctl !== V_IDLE) begin
            errors++; $display("FAIL halt_cycle%0d: got %0d/%b/%h expected %0d/1/%h", n, State, Halted, ctl, ST_HALT, V_IDLE);
         end
         tick();
      end
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      #1;
      checks++;
      if (State !== ST_INIT || Halted !== 1'b0) begin
         errors++; $display("FAIL halt_reset: got %0d/%b expected %0d/0", State, Halted, ST_INIT);
      end
   endtask

   task automatic test_reset_mid_ld();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h40; mem[1] = 8'h1C;          // LD R4,0x40
      mem[8'h40] = 8'h77;
      do_reset();
      repeat (4) tick();
      checks++;
      if (State !== ST_T3) begin
         errors++; $display("FAIL midld_in_t3: got %0d expected %0d", State, ST_T3);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (ctl !== V_IDLE) begin
         errors++; $display("FAIL midld_idle: got %h expected %h", ctl, V_IDLE);
      end
      tick();
      checks++;
      if (State !== ST_INIT || {R[0], R[1], R[2], R[3]} !== 32'h0) begin
         errors++; $display("FAIL midld_abort: got st=%0d regs=%h expected %0d 00000000", State, {R[0], R[1], R[2], R[3]}, ST_INIT);
      end
      Reset = 1'b1;
      #1;
   endtask

   task automatic test_random();
      int cyc;
      int diffs;
      for (int unsigned phase = 0; phase < 6; phase++) begin
         for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'($urandom_range(0, 8'hEF));
            m_mem[i] = mem[i];
         end
         for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
         m_pc = 8'h00;
         m_halted = 1'b0;
         do_reset();
         tick();
         for (int unsigned n = 0; n < 80; n++) begin
            checks++;
            if (State !== ST_T0) begin
               errors++; $display("FAIL rnd_fetch_state p%0d i%0d: got %0d expected %0d", phase, n, State, ST_T0);
            end
            ALUOutFlag = 4'($urandom_range(0, 15));
            isa_step(ALUOutFlag[3], cyc);
            repeat (cyc) tick();
            if (m_halted) begin
               checks++;
               if (State !== ST_HALT || Halted !== 1'b1) begin
                  errors++; $display("FAIL rnd_halt p%0d: got %0d/%b expected %0d/1", phase, State, Halted, ST_HALT);
               end
               break;
            end
            checks++;
            if ({R[0], R[1], R[2], R[3], pc} !== {m_r[0], m_r[1], m_r[2], m_r[3], m_pc}) begin
               errors++; $display("FAIL rnd_regs p%0d i%0d: got %h expected %h", phase, n,
                                  {R[0], R[1], R[2], R[3], pc}, {m_r[0], m_r[1], m_r[2], m_r[3], m_pc});
            end
            diffs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
            checks++;
            if (diffs != 0) begin
               errors++; $display("FAIL rnd_mem p%0d i%0d: got %0d differing bytes expected 0", phase, n, diffs);
            end
         end
      end
   endtask

   initial begin
      Reset      = 1'b0;
      ALUOutFlag = 4'h0;
      ir         = 16'h0000;
      load_directed();
      test_reset();
      test_ldi();
      test_st();
      test_bne();
      test_halt();
      test_reset_mid_ld();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
